// File: rtl/readout_pkg.sv
// readout_pkg: shared readout widths, tag layout and the per-lane Gray decode helper.
package readout_pkg;
  localparam int NUM_ADC_BITS = 12;
  localparam int NUM_LANES    = 20;
  localparam int ROW_W        = 9;
  localparam int PHASE_W      = 2;
  localparam int TAG_W        = ROW_W + PHASE_W;
  typedef struct packed {
    logic [ROW_W-1:0]   row;
    logic [PHASE_W-1:0] phase;
  } tag_t;
  function automatic logic [NUM_ADC_BITS-1:0] gray2bin(input logic [NUM_ADC_BITS-1:0] g);
    logic [NUM_ADC_BITS-1:0] b;
    b[NUM_ADC_BITS-1] = g[NUM_ADC_BITS-1];
    for (int i = NUM_ADC_BITS-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/deser_out_buf.sv
// deser_out_buf: DEPTH-entry valid/ready FIFO; head entry drives o_data.
//   i_clk/i_rst_n  clock, async active-low reset
//   i_push/i_data  write request; accepted when not full or when a pop happens in the same cycle
//   i_pop          consumer handshake (valid && ready)
//   o_data/o_valid head entry and non-empty flag
//   o_full         all DEPTH entries occupied
module deser_out_buf #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  output logic         o_full
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_rd, r_wr;
  logic [AW:0] r_cnt;
  logic w_pop, w_push;
  assign o_full  = r_cnt == (AW+1)'(DEPTH);
  assign o_valid = r_cnt != '0;
  assign o_data  = r_mem[r_rd];
  assign w_pop   = i_pop && o_valid;
  assign w_push  = i_push && (!o_full || w_pop);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_mem[r_wr] <= i_data;
      r_wr  <= r_wr + AW'(w_push);
      r_rd  <= r_rd + AW'(w_pop);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
endmodule

// File: rtl/adc_serial_deserializer.sv
// adc_serial_deserializer: packs serial ADC lane bits into tagged column words and buffers them.
//   TX_CLK/rst_n         clock, async active-low reset
//   re_busy              readout frame active; captures ignored while low
//   ADC_DATA_VALID       bit-valid window; one bit per lane captured on its T_SAMPLE-th cycle
//   ROWADD/PIXLEFTBUCK_SEL/ODDCOL_EN  tag source, latched at bit 0 of each word
//   DATA_IN              one serial bit per lane, MSB first
//   T_SAMPLE             capture cycle within a valid pulse (0 behaves as 1)
//   clr_err              clears sticky errors (a same-cycle error event wins)
//   dout/dout_tag/dout_valid/dout_ready  head of the output FIFO, lane0 in LSBs
//   err_ovf/err_partial/err_short        sticky error flags
// Build option: DESER_GRAY_DECODE_EN converts each lane word Gray->binary on the buffer write path.
module adc_serial_deserializer
  import readout_pkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic                              TX_CLK,
  input  logic                              rst_n,
  input  logic                              re_busy,
  input  logic                              ADC_DATA_VALID,
  input  logic [ROW_W-1:0]                  ROWADD,
  input  logic                              PIXLEFTBUCK_SEL,
  input  logic                              ODDCOL_EN,
  input  logic [NUM_LANES-1:0]              DATA_IN,
  input  logic [31:0]                       T_SAMPLE,
  input  logic                              clr_err,
  output logic [NUM_LANES*NUM_ADC_BITS-1:0] dout,
  output logic [TAG_W-1:0]                  dout_tag,
  output logic                              dout_valid,
  input  logic                              dout_ready,
  output logic                              err_ovf,
  output logic                              err_partial,
  output logic                              err_short
);
  localparam int B  = NUM_ADC_BITS;
  localparam int DW = NUM_LANES*B;
  localparam int CW = $clog2(B);
  logic [31:0] r_pc;
  logic [CW-1:0] r_bit_cnt;
  logic [DW-1:0] r_sh;
  tag_t r_tag;
  logic r_vld_d, r_busy_d, r_got;
  logic [DW-1:0] w_sh_nxt, w_word;
  logic [31:0] w_t;
  logic w_cap, w_done, w_short, w_partial, w_ovf, w_full, w_pop;
  assign w_t       = T_SAMPLE == '0 ? 32'd1 : T_SAMPLE;
  assign w_cap     = re_busy && ADC_DATA_VALID && ({1'b0, r_pc} + 33'd1 == {1'b0, w_t});
  assign w_done    = w_cap && r_bit_cnt == CW'(B-1);
  // r_got remembers whether the pulse that just ended produced a capture
  assign w_short   = re_busy && r_vld_d && !ADC_DATA_VALID && !r_got;
  assign w_partial = r_busy_d && !re_busy && r_bit_cnt != '0;
  assign w_pop     = dout_valid && dout_ready;
  assign w_ovf     = w_done && w_full && !w_pop;
  genvar l;
  for (l = 0; l < NUM_LANES; l++) begin : g_lane
    assign w_sh_nxt[l*B +: B] = {r_sh[l*B +: B-1], DATA_IN[l]};
`ifdef DESER_GRAY_DECODE_EN
    assign w_word[l*B +: B] = gray2bin(w_sh_nxt[l*B +: B]);
`else
    assign w_word[l*B +: B] = w_sh_nxt[l*B +: B];
`endif
  end
  always_ff @(posedge TX_CLK or negedge rst_n)
    if (!rst_n) begin
      r_pc        <= '0;
      r_bit_cnt   <= '0;
      r_sh        <= '0;
      r_tag       <= '0;
      r_vld_d     <= 1'b0;
      r_busy_d    <= 1'b0;
      r_got       <= 1'b0;
      err_ovf     <= 1'b0;
      err_partial <= 1'b0;
      err_short   <= 1'b0;
    end else begin
      r_pc        <= (re_busy && ADC_DATA_VALID) ? (r_pc == '1 ? r_pc : r_pc + 32'd1) : '0;
      r_vld_d     <= ADC_DATA_VALID;
      r_busy_d    <= re_busy;
      r_got       <= ADC_DATA_VALID && (r_got || w_cap);
      if (w_cap) r_sh <= w_sh_nxt;
      if (w_cap && r_bit_cnt == '0) r_tag <= {ROWADD, PIXLEFTBUCK_SEL, ODDCOL_EN};
      r_bit_cnt   <= w_partial ? '0 : w_cap ? (w_done ? '0 : r_bit_cnt + CW'(1)) : r_bit_cnt;
      err_ovf     <= w_ovf     ? 1'b1 : clr_err ? 1'b0 : err_ovf;
      err_partial <= w_partial ? 1'b1 : clr_err ? 1'b0 : err_partial;
      err_short   <= w_short   ? 1'b1 : clr_err ? 1'b0 : err_short;
    end
  // The completed word is pushed on the same edge as the final shift, so it appears one cycle after capture.
  deser_out_buf #(.DEPTH(BUF_DEPTH), .W(DW + TAG_W)) u_buf (
    .i_clk   (TX_CLK),
    .i_rst_n (rst_n),
    .i_push  (w_done),
    .i_data  ({w_word, r_tag}),
    .i_pop   (w_pop),
    .o_data  ({dout, dout_tag}),
    .o_valid (dout_valid),
    .o_full  (w_full)
  );
endmodule

// File: tb/tb_adc_serial_deserializer.sv
// tb_adc_serial_deserializer: directed table-driven bench for adc_serial_deserializer.
module tb_adc_serial_deserializer;
  import readout_pkg::*;
  localparam int B = NUM_ADC_BITS;
  logic TX_CLK = 0, rst_n = 0, re_busy = 0, ADC_DATA_VALID = 0;
  logic PIXLEFTBUCK_SEL = 0, ODDCOL_EN = 0, clr_err = 0, dout_ready = 0;
  logic [8:0] ROWADD = '0;
  logic [NUM_LANES-1:0] DATA_IN = '0;
  logic [31:0] T_SAMPLE = 32'd2;
  logic [NUM_LANES*B-1:0] dout;
  logic [10:0] dout_tag;
  logic dout_valid, err_ovf, err_partial, err_short;
  int n_chk = 0, n_pass = 0;
  typedef struct {
    logic [B-1:0] w;
    logic [8:0]   row;
    logic [1:0]   ph;
    logic [31:0]  ts;
    int           len;
    logic [B-1:0] exp_plain;
    logic [B-1:0] exp_gray;
  } vec_t;
  vec_t vecs [5];
  always #5 TX_CLK = ~TX_CLK;
  adc_serial_deserializer dut (
    .TX_CLK(TX_CLK), .rst_n(rst_n), .re_busy(re_busy), .ADC_DATA_VALID(ADC_DATA_VALID),
    .ROWADD(ROWADD), .PIXLEFTBUCK_SEL(PIXLEFTBUCK_SEL), .ODDCOL_EN(ODDCOL_EN),
    .DATA_IN(DATA_IN), .T_SAMPLE(T_SAMPLE), .clr_err(clr_err),
    .dout(dout), .dout_tag(dout_tag), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .err_ovf(err_ovf), .err_partial(err_partial), .err_short(err_short)
  );
  function automatic logic [B-1:0] g2b(input logic [B-1:0] g);
    logic [B-1:0] r;
    for (int i = 0; i < B; i++) r[i] = ^(g >> i);
    return r;
  endfunction
  function automatic logic [B-1:0] dec(input logic [B-1:0] w);
`ifdef DESER_GRAY_DECODE_EN
    return g2b(w);
`else
    return w;
`endif
  endfunction
  function automatic logic [NUM_LANES-1:0] lanes(input logic b);
    logic [NUM_LANES-1:0] v;
    for (int k = 0; k < NUM_LANES; k++) v[k] = b ^ k[0];
    return v;
  endfunction
  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic tick;
    @(posedge TX_CLK);
    #1;
  endtask
  task automatic send_bit(input logic b, input int len);
    ADC_DATA_VALID = 1'b1;
    DATA_IN = lanes(b);
    repeat (len) tick;
    ADC_DATA_VALID = 1'b0;
    tick;
  endtask
  task automatic send_bits(input logic [B-1:0] w, input int n, input int len);
    for (int i = B-1; i > B-1-n; i--) send_bit(w[i], len);
  endtask
  task automatic chk_word(input string n, input logic [B-1:0] w, input logic [B-1:0] e0, input logic [10:0] tag);
    check({n, "_valid"}, dout_valid, 1);
    check({n, "_lane0"}, dout[B-1:0], e0);
    check({n, "_lane1"}, dout[2*B-1:B], dec(~w));
    check({n, "_lane18"}, dout[19*B-1 -: B], dec(w));
    check({n, "_lane19"}, dout[NUM_LANES*B-1 -: B], dec(~w));
    check({n, "_tag"}, dout_tag, tag);
  endtask
  task automatic pop_one(input string n);
    dout_ready = 1'b1;
    tick;
    dout_ready = 1'b0;
    check({n, "_empty"}, dout_valid, 0);
  endtask
  task automatic clear_errs;
    clr_err = 1'b1;
    tick;
    clr_err = 1'b0;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "timeout");
  end
  initial begin
    logic [B-1:0] w;
    vecs[0] = '{12'hAC3, 9'd5,   2'b01, 32'd2, 4, 12'hAC3, 12'hC82};
    vecs[1] = '{12'h800, 9'd1,   2'b10, 32'd0, 2, 12'h800, 12'hFFF};
    vecs[2] = '{12'h5A5, 9'd511, 2'b11, 32'd3, 3, 12'h5A5, 12'h6C6};
    vecs[3] = '{12'hFFF, 9'd0,   2'b00, 32'd1, 1, 12'hFFF, 12'hAAA};
    vecs[4] = '{12'h000, 9'd300, 2'b10, 32'd4, 6, 12'h000, 12'h000};
    tick;
    tick;
    check("rst_valid", dout_valid, 0);
    check("rst_dout", dout, 0);
    check("rst_tag", dout_tag, 0);
    check("rst_errs", {err_ovf, err_partial, err_short}, 0);
    rst_n = 1'b1;
    re_busy = 1'b1;
    tick;
    // latency and tag latch at bit 0
    w = 12'hAC3;
    T_SAMPLE = 32'd2;
    ROWADD = 9'd5;
    {PIXLEFTBUCK_SEL, ODDCOL_EN} = 2'b01;
    dout_ready = 1'b1;
    for (int i = B-1; i >= 1; i--) begin
      send_bit(w[i], 4);
      ROWADD = 9'd7;
      {PIXLEFTBUCK_SEL, ODDCOL_EN} = 2'b10;
    end
    ADC_DATA_VALID = 1'b1;
    DATA_IN = lanes(w[0]);
    tick;
    check("t1_pre_valid", dout_valid, 0);
    tick;
    chk_word("t1", w, dec(12'hAC3), {9'd5, 2'b01});
    tick;
    check("t1_one_cycle", dout_valid, 0);
    tick;
    ADC_DATA_VALID = 1'b0;
    tick;
    dout_ready = 1'b0;
    // table of words across sample positions and tags
    for (int v = 0; v < 5; v++) begin
      T_SAMPLE = vecs[v].ts;
      ROWADD = vecs[v].row;
      {PIXLEFTBUCK_SEL, ODDCOL_EN} = vecs[v].ph;
      send_bits(vecs[v].w, B, vecs[v].len);
`ifdef DESER_GRAY_DECODE_EN
      chk_word($sformatf("vec%0d", v), vecs[v].w, vecs[v].exp_gray, {vecs[v].row, vecs[v].ph});
`else
      chk_word($sformatf("vec%0d", v), vecs[v].w, vecs[v].exp_plain, {vecs[v].row, vecs[v].ph});
`endif
      pop_one($sformatf("vec%0d", v));
    end
    check("vec_no_errs", {err_ovf, err_partial, err_short}, 0);
    // overflow: third word dropped, first two popped in order
    T_SAMPLE = 32'd2;
    ROWADD = 9'd21;
    {PIXLEFTBUCK_SEL, ODDCOL_EN} = 2'b00;
    send_bits(12'h123, B, 2);
    ROWADD = 9'd22;
    send_bits(12'h456, B, 2);
    check("ovf_not_yet", err_ovf, 0);
    ROWADD = 9'd23;
    send_bits(12'h789, B, 2);
    check("ovf_set", err_ovf, 1);
    chk_word("ovf_head1", 12'h123, dec(12'h123), {9'd21, 2'b00});
    dout_ready = 1'b1;
    tick;
    chk_word("ovf_head2", 12'h456, dec(12'h456), {9'd22, 2'b00});
    tick;
    check("ovf_drained", dout_valid, 0);
    dout_ready = 1'b0;
    clear_errs;
    check("ovf_cleared", err_ovf, 0);
    // partial word on re_busy fall, then pulses ignored while idle
    ROWADD = 9'd9;
    {PIXLEFTBUCK_SEL, ODDCOL_EN} = 2'b10;
    send_bits(12'hFFF, 7, 2);
    re_busy = 1'b0;
    tick;
    check("part_err", err_partial, 1);
    check("part_no_valid", dout_valid, 0);
    send_bit(1'b1, 2);
    send_bit(1'b1, 2);
    re_busy = 1'b1;
    tick;
    ROWADD = 9'd12;
    {PIXLEFTBUCK_SEL, ODDCOL_EN} = 2'b11;
    send_bits(12'h0F0, B, 2);
    chk_word("part_next", 12'h0F0, dec(12'h0F0), {9'd12, 2'b11});
    pop_one("part_next");
    // short pulse: flag set and no shift
    T_SAMPLE = 32'd5;
    send_bit(1'b1, 3);
    check("short_err", err_short, 1);
    T_SAMPLE = 32'd2;
    ROWADD = 9'd40;
    {PIXLEFTBUCK_SEL, ODDCOL_EN} = 2'b01;
    send_bits(12'h3C5, B-1, 2);
    check("short_no_shift", dout_valid, 0);
    send_bit(1'b1, 2);
    chk_word("short_word", 12'h3C5, dec(12'h3C5), {9'd40, 2'b01});
    pop_one("short_word");
    // error event coinciding with clr_err keeps the flag
    T_SAMPLE = 32'd5;
    ADC_DATA_VALID = 1'b1;
    repeat (3) tick;
    ADC_DATA_VALID = 1'b0;
    clr_err = 1'b1;
    tick;
    clr_err = 1'b0;
    check("clr_vs_event", err_short, 1);
    clear_errs;
    check("clr_all", {err_ovf, err_partial, err_short}, 0);
    // async reset mid-word with one buffered entry
    send_bit(1'b1, 3);
    T_SAMPLE = 32'd2;
    ROWADD = 9'd77;
    send_bits(12'h111, B, 2);
    send_bits(12'h222, 6, 2);
    check("pre_rst_valid", dout_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", dout_valid, 0);
    check("arst_dout", dout, 0);
    check("arst_tag", dout_tag, 0);
    check("arst_errs", {err_ovf, err_partial, err_short}, 0);
    tick;
    rst_n = 1'b1;
    tick;
    ROWADD = 9'd78;
    {PIXLEFTBUCK_SEL, ODDCOL_EN} = 2'b10;
    send_bits(12'hA5A, B-1, 2);
    check("post_rst_no_valid", dout_valid, 0);
    send_bit(1'b0, 2);
    chk_word("post_rst", 12'hA5A, dec(12'hA5A), {9'd78, 2'b10});
    pop_one("post_rst");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
